mem_access_ctrl: RTL
====================

# mem_access_ctrl

Clocked requester for the word-addressed asynchronous data memory. It accepts byte, halfword and word load/store requests from the MIPS pipeline's MEM stage and turns each into a legal `ren`/`wen` pulse sequence on the memory port, where `ren` and `wen` are never high together. Sub-word stores are done by read-modify-write. Load data comes back byte-extracted and sign- or zero-extended, and bad requests are answered with an error response.

## Interface
Parameters:
- `WORD_IDX_W`, default 10: number of word-index bits the memory decodes. Legal byte addresses have `req_addr[31:WORD_IDX_W+2] == 0`.

Ports (clock: `clock`; reset: `resetn`, asynchronous assert, active-low):
- `clock`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller idle; the request is accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_signed`  in  1  sign-extend sub-word loads.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle response pulse; no backpressure.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  valid only with `rsp_valid`.
- `mem_ren`  out  1  memory read enable.
- `mem_wen`  out  1  memory write enable.
- `mem_addr`  out  32  word index, `{2'b00, addr[31:2]}`.
- `mem_din`  out  32  memory write data.
- `mem_dout`  in  32  memory read data; combinational while `mem_ren` is high.

## Operation
- Byte lanes are little-endian:
  - a byte at `addr[1:0]=k` occupies bits `8k+7:8k`;
  - a half at `addr[1]=h` occupies bits `16h+15:16h`.
- States: IDLE, RD, GAP, WSETUP, WR, WHOLD, RSP, ERR.
- IDLE:
  - `req_ready` = 1.
  - On accept, latch all `req_*` fields and check for errors.
  - Error conditions: `size == 3`; half with `addr[0]`; word with `addr[1:0] != 0`; out-of-range address. Any error goes to ERR.
  - Otherwise: a load goes to RD; a word store goes to WSETUP; a sub-word store goes to RD.
- RD:
  - `mem_ren` = 1 and `mem_addr` is driven; `mem_dout` is registered at the end of the cycle.
  - Next state: RSP for a load, GAP for a sub-word store.
- GAP:
  - Both enables low.
  - The merged word (read word with the target lane replaced by the low bits of `wdata`) is registered into `mem_din`.
  - Next state: WR.
- WSETUP: `mem_addr` and `mem_din` are driven, enables low. Next state: WR.
- WR: `mem_wen` = 1, with address and data held. Next state: WHOLD.
- WHOLD: `mem_wen` = 0, with address and data still held. Next state: RSP.
- RSP:
  - `rsp_valid` = 1 and `rsp_err` = 0.
  - `rsp_rdata` = extended load data, or 0 for a store.
  - Next state: IDLE.
- ERR: `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0. No memory enable is asserted. Next state: IDLE.
- `mem_addr` and `mem_din` are registered and change only while both enables are low.
- In IDLE, `mem_addr` and `mem_din` hold their last value. `mem_ren` and `mem_wen` come straight from flops, so they are glitch-free.
- Reset:
  - Reset values: IDLE, `mem_ren` = 0, `mem_wen` = 0, `mem_addr` = 0, `mem_din` = 0, `rsp_valid` = 0, `rsp_err` = 0, `rsp_rdata` = 0. `req_ready` follows the state, so it is 1 in IDLE.
  - Reset mid-operation drops the enables immediately. An in-flight write may be partial; the response is lost.

## Timing
- Cycle 0 is the accept edge.
- Load: `ren` high in cycle 1, `rsp_valid` in cycle 2. Latency 2.
- Word store: setup in cycle 1, `wen` in cycle 2, hold in cycle 3, `rsp_valid` in cycle 4. Latency 4.
- Sub-word store: `ren` in cycle 1, gap in cycle 2, `wen` in cycle 3, hold in cycle 4, `rsp_valid` in cycle 5. Latency 5.
- Error: `rsp_valid` in cycle 1.
- Throughput: the next request can be accepted in the cycle after RSP/ERR, because `req_ready` is high only in IDLE.
- `ren` and `wen` are never high in the same or adjacent cycles.

## Structure
- `mem_ctrl_pkg` holds:
  - the `size_e` enum (BYTE, HALF, WORD);
  - the `state_e` enum;
  - the `WORD_IDX_W` default constant.
- Sub-module `mem_lane_unit` is combinational. It takes `size`, `addr[1:0]`, `signed`, `rdword` and `wdata`, and produces `load_ext` and `merged_word`.

## Test plan
- Word store then load: SW `0xDEADBEEF` @ `0x010`, then LW @ `0x010` → `mem_addr` = 4, `wen` pulse only in cycle 2, rsp at cycle 4; load returns `0xDEADBEEF` at cycle 2.
- Signed/unsigned byte: word `0x80FF7F01` @ `0x020`; LB @ `0x023` → `0xFFFFFF80`; LBU @ `0x023` → `0x00000080`; LH @ `0x022` → `0xFFFF80FF`.
- Sub-word store RMW: word `0x11223344` @ `0x030`; SB `0xAA` @ `0x031` → one `ren` then one `wen` with a 1-cycle gap; memory holds `0x1122AA44`; rsp at cycle 5.
- Errors: LW @ `0x002`, SH @ `0x001`, size 3, LW @ `0x1000` → `rsp_err` = 1 at cycle 1, `mem_ren`/`mem_wen` never asserted, `rsp_rdata` = 0.
- Protocol monitor over 1000 random requests: `ren&wen` never true, `mem_addr`/`mem_din` stable whenever either enable is high, `req_ready` low from accept through RSP.
- Reset during WR: drop `resetn` mid-cycle → `mem_wen` = 0 immediately with no clock edge, no `rsp_valid`, `req_ready` = 1 after release.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory requester.
// Also holds the request-shape check shared by the controller.
package mem_ctrl_pkg;

    localparam int WORD_IDX_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        GAP,
        WSETUP,
        WR,
        WHOLD,
        RSP,
        ERR
    } state_e;

    // True when the size code is illegal or the address is not naturally aligned.
    function automatic logic bad_shape(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = lo[0];
            2'd2:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-port bundle for mem_access_ctrl.
// slave is the controller's view; master is the pipeline/memory side.
interface mem_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_ren, mem_wen, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_ren, mem_wen, mem_addr, mem_din
    );

endinterface

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane logic: extracts/extends load data and builds the
// read-modify-write word for sub-word stores (little-endian lanes).
module mem_lane_unit
    import mem_ctrl_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] rdword,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdword[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdword[7:0];
            2'd1:    byte_sel = rdword[15:8];
            2'd2:    byte_sel = rdword[23:16];
            default: byte_sel = rdword[31:24];
        endcase
        half_sel = addr_lo[1] ? rdword[31:16] : rdword[15:0];

        load_ext = rdword;
        case (size)
            BYTE:    load_ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            HALF:    load_ext = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_ext = rdword;
        endcase
    end

    // Each lane takes store data when the access covers it, else keeps the read byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_hit;
            logic [7:0] lane_src;

            assign lane_hit = (size == WORD)
                           || ((size == HALF) && (addr_lo[1] == LANE[1]))
                           || ((size == BYTE) && (addr_lo == LANE));

            assign lane_src = (size == WORD) ? wdata[8*gi +: 8]
                            : (size == HALF) ? wdata[8*(gi % 2) +: 8]
                            : wdata[7:0];

            assign merged_word[8*gi +: 8] = lane_hit ? lane_src : rdword[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage requester for a word-addressed asynchronous memory: sequences
// ren/wen pulses, does RMW for sub-word stores and returns extended load data.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_IDX_W = WORD_IDX_W_DEFAULT
)(
    input  logic             clock,
    input  logic             resetn,
    mem_access_ctrl_if.slave bus
);

    localparam logic [31:0] HI_MASK = ~((32'd1 << (WORD_IDX_W + 2)) - 32'd1);

    state_e      state_reg,   state_next;
    logic        we_reg,      we_next;
    size_e       size_reg,    size_next;
    logic        sign_reg,    sign_next;
    logic [1:0]  addr_lo_reg, addr_lo_next;
    logic [31:0] wdata_reg,   wdata_next;

    logic        mem_ren_reg,   mem_ren_next;
    logic        mem_wen_reg,   mem_wen_next;
    logic [31:0] mem_addr_reg,  mem_addr_next;
    logic [31:0] mem_din_reg,   mem_din_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic        rsp_err_reg,   rsp_err_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;

    logic        req_err;
    logic [31:0] load_ext;
    logic [31:0] merged_word;

    assign req_err = bad_shape(bus.req_size, bus.req_addr[1:0]) | (|(bus.req_addr & HI_MASK));

    // Lane logic sees the live memory word; it is only consumed during RD.
    mem_lane_unit u_lane (
        .size        (size_reg),
        .addr_lo     (addr_lo_reg),
        .sign_ext    (sign_reg),
        .rdword      (bus.mem_dout),
        .wdata       (wdata_reg),
        .load_ext    (load_ext),
        .merged_word (merged_word)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            size_reg      <= BYTE;
            sign_reg      <= 1'b0;
            addr_lo_reg   <= 2'b00;
            wdata_reg     <= 32'd0;
            mem_ren_reg   <= 1'b0;
            mem_wen_reg   <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_din_reg   <= 32'd0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            we_reg        <= we_next;
            size_reg      <= size_next;
            sign_reg      <= sign_next;
            addr_lo_reg   <= addr_lo_next;
            wdata_reg     <= wdata_next;
            mem_ren_reg   <= mem_ren_next;
            mem_wen_reg   <= mem_wen_next;
            mem_addr_reg  <= mem_addr_next;
            mem_din_reg   <= mem_din_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        we_next        = we_reg;
        size_next      = size_reg;
        sign_next      = sign_reg;
        addr_lo_next   = addr_lo_reg;
        wdata_next     = wdata_reg;
        mem_ren_next   = 1'b0;
        mem_wen_next   = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_din_next   = mem_din_reg;
        rsp_valid_next = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = 32'd0;

        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    we_next      = bus.req_we;
                    size_next    = size_e'(bus.req_size);
                    sign_next    = bus.req_signed;
                    addr_lo_next = bus.req_addr[1:0];
                    wdata_next   = bus.req_wdata;
                    if (req_err) begin
                        state_next     = ERR;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                    end else begin
                        // Address (and word-store data) settle while enables are still low.
                        mem_addr_next = {2'b00, bus.req_addr[31:2]};
                        if (bus.req_we && (bus.req_size == 2'd2)) begin
                            state_next   = WSETUP;
                            mem_din_next = bus.req_wdata;
                        end else begin
                            state_next   = RD;
                            mem_ren_next = 1'b1;
                        end
                    end
                end
            end
            RD: begin
                if (!we_reg) begin
                    state_next     = RSP;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = load_ext;
                end else begin
                    // Merge captured as ren drops, so mem_din is steady through GAP.
                    state_next   = GAP;
                    mem_din_next = merged_word;
                end
            end
            GAP: begin
                state_next   = WR;
                mem_wen_next = 1'b1;
            end
            WSETUP: begin
                state_next   = WR;
                mem_wen_next = 1'b1;
            end
            WR: begin
                state_next = WHOLD;
            end
            WHOLD: begin
                state_next     = RSP;
                rsp_valid_next = 1'b1;
            end
            RSP: begin
                state_next = IDLE;
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.mem_ren   = mem_ren_reg;
    assign bus.mem_wen   = mem_wen_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_din   = mem_din_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;

endmodule
